// File: rtl/roi_downsampler_pkg.sv
// Shared constants and state encoding for the camera front end that
// feeds the digit classifier.
package roi_downsampler_pkg;

  localparam int DS_GRAY_WIDTH = 8;
  localparam int DS_OUT_DIM    = 28;
  localparam int DS_OUT_PIXELS = DS_OUT_DIM * DS_OUT_DIM;
  localparam int DS_SCALE_LOG2 = 3;
  localparam int DS_HSUM_WIDTH = DS_GRAY_WIDTH + DS_SCALE_LOG2;
  localparam int DS_ACC_WIDTH  = DS_GRAY_WIDTH + 2 * DS_SCALE_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } ds_state_e;

endpackage

// File: rtl/roi_downsampler_block_accumulator.sv
// Box-sum engine: a horizontal partial sum plus one column accumulator per
// output column. Reports the full block total on the block's last pixel.
module roi_downsampler_block_accumulator
  import roi_downsampler_pkg::*;
#(
  parameter int GRAY_WIDTH = DS_GRAY_WIDTH,
  parameter int SCALE_LOG2 = DS_SCALE_LOG2,
  parameter int OUT_DIM    = DS_OUT_DIM
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 pix_valid,
  input  logic [GRAY_WIDTH-1:0]                pixel,
  input  logic [$clog2(OUT_DIM)-1:0]           bx,
  input  logic [SCALE_LOG2-1:0]                sx,
  input  logic [SCALE_LOG2-1:0]                sy,
  output logic                                 blk_valid,
  output logic [GRAY_WIDTH+2*SCALE_LOG2-1:0]   blk_sum
);

  localparam int HW = GRAY_WIDTH + SCALE_LOG2;
  localparam int AW = GRAY_WIDTH + 2 * SCALE_LOG2;

  logic [HW-1:0] hsum_q, hsum_d, hsum_full;
  logic [AW-1:0] col_acc_q [OUT_DIM];
  logic [AW-1:0] col_acc_d [OUT_DIM];

  always_comb begin
    hsum_full = (sx == '0) ? HW'(pixel) : hsum_q + HW'(pixel);
    hsum_d    = hsum_q;
    col_acc_d = col_acc_q;
    blk_valid = 1'b0;
    blk_sum   = '0;
    if (clear) begin
      hsum_d = '0;
      for (int i = 0; i < OUT_DIM; i++) col_acc_d[i] = '0;
    end else if (pix_valid) begin
      hsum_d = hsum_full;
      if (&sx) begin
        // First block row overwrites, so stale sums never need an explicit clear.
        if (&sy) begin
          blk_valid = 1'b1;
          blk_sum   = col_acc_q[bx] + AW'(hsum_full);
        end else if (sy == '0) begin
          col_acc_d[bx] = AW'(hsum_full);
        end else begin
          col_acc_d[bx] = col_acc_q[bx] + AW'(hsum_full);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsum_q <= '0;
      for (int i = 0; i < OUT_DIM; i++) col_acc_q[i] <= '0;
    end else begin
      hsum_q    <= hsum_d;
      col_acc_q <= col_acc_d;
    end
  end

endmodule

// File: rtl/roi_downsampler.sv
// Crops a fixed ROI from a raw gray frame and box-averages it down to an
// OUT_DIM x OUT_DIM raster stream for the classifier.
module roi_downsampler
  import roi_downsampler_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ROI_X      = 208,
  parameter int ROI_Y      = 128,
  parameter int SCALE_LOG2 = DS_SCALE_LOG2,
  parameter int OUT_DIM    = DS_OUT_DIM,
  parameter int GRAY_WIDTH = DS_GRAY_WIDTH,
  parameter int INVERT     = 1
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  vsync_in,
  input  logic                  de_in,
  input  logic [GRAY_WIDTH-1:0] pixel_in,
  output logic                  de_out,
  output logic [GRAY_WIDTH-1:0] pixel_out,
  output logic                  frame_done,
  output logic                  frame_short
);

  localparam int ROI_EDGE   = OUT_DIM << SCALE_LOG2;
  localparam int OUT_PIXELS = OUT_DIM * OUT_DIM;
  localparam int XW  = $clog2(IMG_WIDTH + 1);
  localparam int YW  = $clog2(IMG_HEIGHT + 1);
  localparam int BXW = $clog2(OUT_DIM);
  localparam int RW  = SCALE_LOG2 + BXW;
  localparam int CW  = $clog2(OUT_PIXELS + 1);
  localparam int AW  = GRAY_WIDTH + 2 * SCALE_LOG2;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [XW-1:0] X_ROI0 = XW'(ROI_X);
  localparam logic [XW-1:0] X_ROI1 = XW'(ROI_X + ROI_EDGE);
  localparam logic [YW-1:0] Y_END  = YW'(IMG_HEIGHT);
  localparam logic [YW-1:0] Y_ROI0 = YW'(ROI_Y);
  localparam logic [YW-1:0] Y_ROI1 = YW'(ROI_Y + ROI_EDGE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_PIXELS - 1);

  ds_state_e             state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  vsync_q;
  logic                  de_out_q, de_out_d;
  logic [GRAY_WIDTH-1:0] pixel_out_q, pixel_out_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_short_q, frame_short_d;

  logic                  vs_edge, pix_step, in_roi, pix_valid, blk_valid;
  logic [RW-1:0]         rel_x;
  logic [SCALE_LOG2-1:0] sy;
  logic [AW-1:0]         blk_sum;
  logic [GRAY_WIDTH-1:0] avg, pixel_val;

  // A vsync edge always wins over a coincident de_in.
  assign vs_edge   = vsync_in & ~vsync_q;
  assign pix_step  = ~vs_edge & (state_q == ST_ACTIVE) & de_in & (y_q != Y_END);
  assign in_roi    = (x_q >= X_ROI0) && (x_q < X_ROI1) && (y_q >= Y_ROI0) && (y_q < Y_ROI1);
  assign pix_valid = pix_step & in_roi;
  assign rel_x     = x_q[RW-1:0] - X_ROI0[RW-1:0];
  assign sy        = y_q[SCALE_LOG2-1:0] - Y_ROI0[SCALE_LOG2-1:0];
  assign avg       = GRAY_WIDTH'(blk_sum >> (2 * SCALE_LOG2));
  assign pixel_val = (INVERT != 0) ? ~avg : avg;

  roi_downsampler_block_accumulator #(
    .GRAY_WIDTH (GRAY_WIDTH),
    .SCALE_LOG2 (SCALE_LOG2),
    .OUT_DIM    (OUT_DIM)
  ) u_block_accumulator (
    .clk       (pclk),
    .rst       (rst),
    .clear     (vs_edge),
    .pix_valid (pix_valid),
    .pixel     (pixel_in),
    .bx        (rel_x[RW-1:SCALE_LOG2]),
    .sx        (rel_x[SCALE_LOG2-1:0]),
    .sy        (sy),
    .blk_valid (blk_valid),
    .blk_sum   (blk_sum)
  );

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    cnt_d         = cnt_q;
    de_out_d      = 1'b0;
    pixel_out_d   = pixel_out_q;
    frame_done_d  = 1'b0;
    frame_short_d = 1'b0;
    if (vs_edge) begin
      state_d       = ST_ACTIVE;
      x_d           = '0;
      y_d           = '0;
      cnt_d         = '0;
      frame_short_d = (state_q == ST_ACTIVE);
    end else if (pix_step) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      if (blk_valid) begin
        de_out_d    = 1'b1;
        pixel_out_d = pixel_val;
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          frame_done_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      vsync_q       <= 1'b0;
      de_out_q      <= 1'b0;
      pixel_out_q   <= '0;
      frame_done_q  <= 1'b0;
      frame_short_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cnt_q         <= cnt_d;
      vsync_q       <= vsync_in;
      de_out_q      <= de_out_d;
      pixel_out_q   <= pixel_out_d;
      frame_done_q  <= frame_done_d;
      frame_short_q <= frame_short_d;
    end
  end

  assign de_out      = de_out_q;
  assign pixel_out   = pixel_out_q;
  assign frame_done  = frame_done_q;
  assign frame_short = frame_short_q;

endmodule

// File: tb/tb_roi_downsampler.sv
// Randomized frame-level bench for roi_downsampler: two instances (raw and
// inverted) share one stimulus stream and are scored against box averages.
module tb_roi_downsampler;

  localparam int IW = 64;
  localparam int IH = 64;
  localparam int RX = 4;
  localparam int RY = 3;
  localparam int SL = 1;
  localparam int S  = 1 << SL;
  localparam int OD = 28;
  localparam int GW = 8;
  localparam int W  = GW + 1;

  logic          pclk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync_in = 1'b0;
  logic          de_in = 1'b0;
  logic [GW-1:0] pixel_in = '0;
  logic          de_out_raw, frame_done_raw, frame_short_raw;
  logic          de_out_inv, frame_done_inv, frame_short_inv;
  logic [GW-1:0] pixel_out_raw, pixel_out_inv;

  logic [GW-1:0] img [IH][IW];
  logic [W-1:0]  exp_raw_q[$];
  logic [W-1:0]  exp_inv_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int out_seen = 0;
  int done_raw_cnt = 0, done_inv_cnt = 0;
  int short_raw_cnt = 0, short_inv_cnt = 0;
  int exp_done = 0, exp_short = 0, exp_n = 0;

  always #5 pclk = ~pclk;

  roi_downsampler #(
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .ROI_X(RX), .ROI_Y(RY),
    .SCALE_LOG2(SL), .OUT_DIM(OD), .GRAY_WIDTH(GW), .INVERT(0)
  ) dut_raw (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .de_in(de_in), .pixel_in(pixel_in),
    .de_out(de_out_raw), .pixel_out(pixel_out_raw),
    .frame_done(frame_done_raw), .frame_short(frame_short_raw)
  );

  roi_downsampler #(
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .ROI_X(RX), .ROI_Y(RY),
    .SCALE_LOG2(SL), .OUT_DIM(OD), .GRAY_WIDTH(GW), .INVERT(1)
  ) dut_inv (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .de_in(de_in), .pixel_in(pixel_in),
    .de_out(de_out_inv), .pixel_out(pixel_out_inv),
    .frame_done(frame_done_inv), .frame_short(frame_short_inv)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // mode 0 uniform 100, 1 column ramp, 2 one bright block, else random
  task automatic build_frame(input int mode);
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < IW; x++) begin
        case (mode)
          0: img[y][x] = 8'd100;
          1: img[y][x] = GW'((x >> SL) & 255);
          2: img[y][x] = (x >= RX + 5 * S && x < RX + 6 * S &&
                          y >= RY + 3 * S && y < RY + 4 * S) ? 8'd255 : 8'd0;
          default: img[y][x] = GW'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  // Expected outputs: every block whose last row lies within the lines driven.
  task automatic push_expected(input int lines);
    int sum, avg;
    logic done;
    exp_n = 0;
    for (int by = 0; by < OD; by++) begin
      for (int bx = 0; bx < OD; bx++) begin
        if (RY + by * S + S - 1 < lines) begin
          sum = 0;
          for (int dy = 0; dy < S; dy++)
            for (int dx = 0; dx < S; dx++)
              sum += int'(img[RY + by * S + dy][RX + bx * S + dx]);
          avg  = sum / (S * S);
          done = (by == OD - 1) && (bx == OD - 1);
          exp_raw_q.push_back({done, GW'(avg)});
          exp_inv_q.push_back({done, GW'(255 - avg)});
          exp_n++;
        end
      end
    end
  endtask

  task automatic drive_frame(input int lines, input bit coincide, input int rst_at);
    bit rst_done = 1'b0;
    out_seen = 0;
    if (coincide) begin
      vsync_in = 1'b1; de_in = 1'b1; pixel_in = 8'hFF;
      tick();
      vsync_in = 1'b0; de_in = 1'b0;
    end else begin
      vsync_in = 1'b1; de_in = 1'b0;
      tick(); tick();
      vsync_in = 1'b0;
      tick();
    end
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < IW; x++) begin
        if ($urandom_range(0, 7) == 0) begin
          de_in = 1'b0; pixel_in = GW'($urandom);
          tick();
        end
        de_in = 1'b1; pixel_in = img[y][x];
        tick();
        if (rst_at > 0 && !rst_done && out_seen >= rst_at) begin
          de_in = 1'b0; rst = 1'b1;
          tick();
          rst = 1'b0;
          exp_raw_q.delete();
          exp_inv_q.delete();
          rst_done = 1'b1;
          exp_n = out_seen;
        end
      end
    end
    de_in = 1'b0;
    repeat (4) tick();
    if (rst_at > 0) check_eq("rst_applied", 32'(rst_done), 32'd1);
  endtask

  task automatic end_of_frame_checks();
    check_eq("out_count", out_seen, exp_n);
    check_eq("left_raw", exp_raw_q.size(), 0);
    check_eq("left_inv", exp_inv_q.size(), 0);
    check_eq("done_raw", done_raw_cnt, exp_done);
    check_eq("done_inv", done_inv_cnt, exp_done);
    check_eq("short_raw", short_raw_cnt, exp_short);
    check_eq("short_inv", short_inv_cnt, exp_short);
  endtask

  // Scoreboard: entries are {frame_done, pixel_out} in raster order.
  always @(negedge pclk) begin
    logic [W-1:0] e;
    if (de_out_raw) begin
      out_seen++;
      if (exp_raw_q.size() == 0) check_eq("extra_out_raw", 32'(de_out_raw), 32'd0);
      else begin
        e = exp_raw_q.pop_front();
        check_eq("pix_raw", 32'({frame_done_raw, pixel_out_raw}), 32'(e));
      end
    end else if (frame_done_raw) check_eq("stray_done_raw", 32'(frame_done_raw), 32'd0);
    if (de_out_inv) begin
      if (exp_inv_q.size() == 0) check_eq("extra_out_inv", 32'(de_out_inv), 32'd0);
      else begin
        e = exp_inv_q.pop_front();
        check_eq("pix_inv", 32'({frame_done_inv, pixel_out_inv}), 32'(e));
      end
    end else if (frame_done_inv) check_eq("stray_done_inv", 32'(frame_done_inv), 32'd0);
    if (frame_done_raw) done_raw_cnt++;
    if (frame_done_inv) done_inv_cnt++;
    if (frame_short_raw) short_raw_cnt++;
    if (frame_short_inv) short_inv_cnt++;
  end

  initial begin
    repeat (95000) @(posedge pclk);
    $display("FAIL watchdog: got no completion, expected finish within 95000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_de_out", 32'(de_out_raw), 32'd0);
    check_eq("rst_pixel_out", 32'(pixel_out_inv), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done_raw), 32'd0);
    check_eq("rst_frame_short", 32'(frame_short_inv), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // uniform, column ramp, single bright block
    for (int m = 0; m < 3; m++) begin
      build_frame(m);
      push_expected(IH);
      exp_done++;
      drive_frame(IH, 1'b0, 0);
      end_of_frame_checks();
    end

    // short frame: pulse arrives at the next vsync edge
    build_frame(3);
    push_expected(30);
    drive_frame(30, 1'b0, 0);
    end_of_frame_checks();

    build_frame(3);
    push_expected(IH);
    exp_short++;
    exp_done++;
    drive_frame(IH, 1'b0, 0);
    end_of_frame_checks();

    // reset after 400 outputs; nothing more until the next vsync
    build_frame(3);
    push_expected(IH);
    drive_frame(IH, 1'b0, 400);
    end_of_frame_checks();

    build_frame(3);
    push_expected(IH);
    exp_done++;
    drive_frame(IH, 1'b0, 0);
    end_of_frame_checks();

    // vsync edge coincident with a bright de_in pixel
    build_frame(3);
    push_expected(IH);
    exp_done++;
    drive_frame(IH, 1'b1, 0);
    end_of_frame_checks();

    // vsync from DONE must not report a short frame
    vsync_in = 1'b1;
    tick(); tick();
    vsync_in = 1'b0;
    repeat (3) tick();
    check_eq("short_from_done", short_raw_cnt, exp_short);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
